// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the streaming convolution layer.
//   clog2 / max1   : width helpers used for counter and index sizing
//   acc_width      : accumulator width that holds K*K products plus bias
//   state_t        : layer FSM states
//   relu / sat     : requantisation helpers working on a 64-bit signed value
package conv_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Zero-width buses are illegal, so indices always get at least one bit.
    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + clog2(k * k) + 1;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] v);
        return (v < 0) ? 64'sd0 : v;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/conv_stream_layer_if.sv
// conv_stream_layer_if: pixel-in / result-out streams plus coefficient write port.
//   slave  : the layer's view (consumes pixels and coefficients, produces results)
//   master : the environment's view (pixel source, coefficient loader, sink)
interface conv_stream_layer_if
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int KERNEL_NUM  = 64
);
    localparam int KW = max1(clog2(KERNEL_NUM));
    localparam int TW = max1(clog2(KERNEL_SIZE * KERNEL_SIZE + 1));

    logic                             w_we;
    logic [KW-1:0]                    w_kernel;
    logic [TW-1:0]                    w_tap;
    logic [DATA_WIDTH-1:0]            w_data;
    logic                             in_valid;
    logic                             in_ready;
    logic [DATA_WIDTH-1:0]            in_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [KERNEL_NUM*DATA_WIDTH-1:0] out_data;
    logic                             out_last;

    modport master (
        output w_we, w_kernel, w_tap, w_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  w_we, w_kernel, w_tap, w_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/conv_mac_unit.sv
// conv_mac_unit: one output channel of the convolution layer.
//   clk, reset  : clock, async active-low reset (clears coefficients and stages)
//   en          : global pipeline enable
//   coef_we     : coefficient write strobe, already gated to the IDLE state
//   w_kernel    : target filter; this unit responds when it equals IDX
//   w_tap       : 0..K*K-1 weight (row-major), K*K bias
//   w_data      : signed coefficient
//   win         : KxK window, tap r*K+c at win[r*K+c]
//   res         : stage-2 requantised result
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int KERNEL_NUM  = 64,
    parameter int OUT_SHIFT   = 7,
    parameter int RELU_EN     = 1,
    parameter int IDX         = 0,
    localparam int KW   = max1(clog2(KERNEL_NUM)),
    localparam int TW   = max1(clog2(KERNEL_SIZE * KERNEL_SIZE + 1)),
    localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             coef_we,
    input  logic [KW-1:0]                    w_kernel,
    input  logic [TW-1:0]                    w_tap,
    input  logic [DATA_WIDTH-1:0]            w_data,
    input  logic [TAPS-1:0][DATA_WIDTH-1:0]  win,
    output logic [DATA_WIDTH-1:0]            res
);
    localparam int ACC_W = acc_width(DATA_WIDTH, KERNEL_SIZE);

    logic signed [DATA_WIDTH-1:0] wt [TAPS];
    logic signed [DATA_WIDTH-1:0] bias;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      acc;
    logic signed [63:0]           shv;
    logic [DATA_WIDTH-1:0]        res_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < TAPS; t++) wt[t] <= '0;
            bias <= '0;
        end else if (coef_we && w_kernel == KW'(IDX)) begin
            for (int t = 0; t < TAPS; t++)
                if (w_tap == TW'(t)) wt[t] <= w_data;
            if (w_tap == TW'(TAPS)) bias <= w_data;
        end
    end

    // Bias is pre-scaled so it lands in the same fixed-point position as the result.
    always_comb begin
        sum = ACC_W'(bias) <<< OUT_SHIFT;
        for (int t = 0; t < TAPS; t++)
            sum = sum + ACC_W'(signed'(win[t])) * ACC_W'(wt[t]);
    end

    // Arithmetic shift floors toward -inf; ReLU happens before saturation.
    always_comb begin
        shv   = 64'(acc) >>> OUT_SHIFT;
        res_d = DATA_WIDTH'(sat((RELU_EN != 0) ? relu(shv) : shv, DATA_WIDTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            res <= '0;
        end else if (en) begin
            acc <= sum;
            res <= res_d;
        end
    end

endmodule

// File: rtl/conv_stream_layer.sv
// conv_stream_layer: streaming KxK valid-mode convolution, KERNEL_NUM filters.
//   clk, reset : clock, async active-low reset
//   bus        : pixel stream in, result stream out, coefficient writes
//   busy       : high while a frame is streaming or draining
// Pipeline: stage 0 registers the window, stage 1 the accumulators, stage 2 the
// requantised outputs. Everything advances on en = !out_valid || out_ready.
module conv_stream_layer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 224,
    parameter int IMAGE_HEIGHT = 224,
    parameter int KERNEL_SIZE  = 3,
    parameter int KERNEL_NUM   = 64,
    parameter int OUT_SHIFT    = 7,
    parameter int RELU_EN      = 1
) (
    input  logic                clk,
    input  logic                reset,
    conv_stream_layer_if.slave  bus,
    output logic                busy
);
    localparam int K      = KERNEL_SIZE;
    localparam int TAPS   = K * K;
    localparam int CW     = max1(clog2(IMAGE_WIDTH));
    localparam int RW     = max1(clog2(IMAGE_HEIGHT));
    localparam int STAGES = 2;

    state_t                          state, state_nxt;
    logic [CW-1:0]                   col;
    logic [RW-1:0]                   row;
    logic                            en, acc_pix, win_vld, pos_last, coef_we;
    logic [STAGES:0]                 vld_pipe, last_pipe;
    logic [DATA_WIDTH-1:0]           lb [K-1][IMAGE_WIDTH];
    logic [K-1:0][DATA_WIDTH-1:0]    cv;
    logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win;
    logic [TAPS-1:0][DATA_WIDTH-1:0] win_flat;
    logic [KERNEL_NUM-1:0][DATA_WIDTH-1:0] res;

    assign en           = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready = en;
    assign acc_pix      = bus.in_valid && en;
    assign win_vld      = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
    assign pos_last     = (row == RW'(IMAGE_HEIGHT - 1)) && (col == CW'(IMAGE_WIDTH - 1));
    assign coef_we      = bus.w_we && (state == IDLE);
    assign busy         = (state != IDLE);

    // New column of the window: top row is the oldest line buffer, bottom is
    // the incoming pixel.
    always_comb begin
        cv = '0;
        for (int r = 0; r < K - 1; r++) cv[r] = lb[K-2-r][col];
        cv[K-1] = bus.in_data;
    end

    // Line buffers and window are pure datapath; qualified by vld_pipe only.
    always_ff @(posedge clk) begin
        if (acc_pix) begin
            lb[0][col] <= bus.in_data;
            for (int j = 1; j < K - 1; j++) lb[j][col] <= lb[j-1][col];
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
                win[r][K-1] <= cv[r];
            end
        end
    end

    // Row-major packing of [r][c] matches tap index r*K+c.
    assign win_flat = win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            if (en) begin
                vld_pipe  <= {vld_pipe[STAGES-1:0], acc_pix && win_vld};
                last_pipe <= {last_pipe[STAGES-1:0], acc_pix && pos_last};
            end
            if (acc_pix) begin
                if (col == CW'(IMAGE_WIDTH - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMAGE_HEIGHT - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // A pixel arriving in DRAIN starts the next frame while the old one drains.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (acc_pix) state_nxt = STREAM;
            STREAM:  if (acc_pix && pos_last) state_nxt = DRAIN;
            DRAIN: begin
                if (acc_pix)            state_nxt = pos_last ? DRAIN : STREAM;
                else if (vld_pipe == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar n = 0; n < KERNEL_NUM; n++) begin : g_mac
        conv_mac_unit #(
            .DATA_WIDTH (DATA_WIDTH),
            .KERNEL_SIZE(KERNEL_SIZE),
            .KERNEL_NUM (KERNEL_NUM),
            .OUT_SHIFT  (OUT_SHIFT),
            .RELU_EN    (RELU_EN),
            .IDX        (n)
        ) u_mac (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .coef_we (coef_we),
            .w_kernel(bus.w_kernel),
            .w_tap   (bus.w_tap),
            .w_data  (bus.w_data),
            .win     (win_flat),
            .res     (res[n])
        );
    end

    assign bus.out_data  = res;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_last  = last_pipe[STAGES];

endmodule
